// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer between myROM and decode: owns the PC, captures ROM words into an IR,
// and offers them over valid/ready. Optional FETCH_STAT_EN adds a saturating handshake counter.
module instr_fetch_ctrl #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
`ifdef FETCH_STAT_EN
    output logic [15:0]       fetch_count,
`endif
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [DATA_W-1:0]   ir_q;
    logic [ADDR_W-1:0]   ir_pc_q;
    logic                ir_valid_q;
    logic                halted_q;
    logic [ADDR_W-1:0]   pc_inc_c;
    logic                handshake_c;

    // Natural ADDR_W-bit wrap gives the modulo PC increment.
    assign pc_inc_c    = pc_q + ADDR_W'(1);
    // A halt on the same edge discards the pending IR, so it is not counted as consumed.
    assign handshake_c = (state_q == ST_HOLD) && ir_valid_q && ir_ready && !halt;

    // Fetch FSM: Reset > halt > redirect > normal step; HALT is left only by Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_ISSUE;
            pc_q       <= ADDR_W'(RESET_PC);
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else if (state_q != ST_HALT) begin
            if (halt) begin
                state_q    <= ST_HALT;
                ir_valid_q <= 1'b0;
                halted_q   <= 1'b1;
            end else if (redirect) begin
                state_q    <= ST_ISSUE;
                pc_q       <= redirect_pc;
                ir_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ISSUE: begin
                        state_q <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        ir_q       <= rom_q;
                        ir_pc_q    <= pc_q;
                        ir_valid_q <= 1'b1;
                        pc_q       <= pc_inc_c;
                        state_q    <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (ir_ready) begin
                            ir_valid_q <= 1'b0;
                            state_q    <= ST_ISSUE;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

`ifdef FETCH_STAT_EN
    logic [15:0] fetch_count_q;

    // Saturating count of accepted instructions; only Reset clears it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_count_q <= '0;
        end else if (handshake_c && !(&fetch_count_q)) begin
            fetch_count_q <= fetch_count_q + 16'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake_c;
`endif

    assign rom_addr = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural 1-cycle synchronous ROM.
module tb_instr_fetch_ctrl;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              halted;
`ifdef FETCH_STAT_EN
    logic [15:0]       fetch_count;
`endif

    logic [DATA_W-1:0] mem [0:127];

    int n_chk = 0;
    int n_err = 0;

    instr_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
        .Clk         (clk),
        .Reset       (rst),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
`ifdef FETCH_STAT_EN
        .fetch_count (fetch_count),
`endif
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) rom_q <= mem[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h5A00 + 16'(i);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        rom_q       = '0;
        rst         = 1'b1;
        ir_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;

        // Test 1: reset state, first-fetch latency, 3-cycle throughput
        step(2);
        check_eq("rst_valid",  32'(ir_valid), 32'd0);
        check_eq("rst_halted", 32'(halted),   32'd0);
        check_eq("rst_addr",   32'(rom_addr), 32'd0);
        check_eq("rst_ir",     32'(ir),       32'd0);
        check_eq("rst_irpc",   32'(ir_pc),    32'd0);
`ifdef FETCH_STAT_EN
        check_eq("rst_cnt",    32'(fetch_count), 32'd0);
`endif
        rst = 1'b0;
        step(1);
        check_eq("t1_valid_e1", 32'(ir_valid), 32'd0);
        step(1);
        check_eq("t1_valid0", 32'(ir_valid), 32'd1);
        check_eq("t1_ir0",    32'(ir),       32'h1111);
        check_eq("t1_irpc0",  32'(ir_pc),    32'd0);
        check_eq("t1_addr1",  32'(rom_addr), 32'd1);
        step(1);
        check_eq("t1_hs_drop", 32'(ir_valid), 32'd0);
        step(1);
        check_eq("t1_gap",     32'(ir_valid), 32'd0);
        step(1);
        check_eq("t1_valid1", 32'(ir_valid), 32'd1);
        check_eq("t1_ir1",    32'(ir),       32'h2222);
        check_eq("t1_irpc1",  32'(ir_pc),    32'd1);

        // Test 2: backpressure holds IR and PC stable
        ir_ready = 1'b0;
        do_reset();
        step(2);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_eq("t2_valid", 32'(ir_valid), 32'd1);
            check_eq("t2_ir",    32'(ir),       32'h1111);
            check_eq("t2_irpc",  32'(ir_pc),    32'd0);
            check_eq("t2_addr",  32'(rom_addr), 32'd1);
        end
        ir_ready = 1'b1;
        step(1);
        check_eq("t2_release", 32'(ir_valid), 32'd0);
        step(2);
        check_eq("t2_next_irpc", 32'(ir_pc), 32'd1);

        // Test 3: redirect coincident with a HOLD handshake
        redirect    = 1'b1;
        redirect_pc = 7'h40;
        step(1);
        redirect = 1'b0;
        check_eq("t3_flush", 32'(ir_valid), 32'd0);
        check_eq("t3_addr",  32'(rom_addr), 32'h40);
        step(1);
        check_eq("t3_gap", 32'(ir_valid), 32'd0);
        step(1);
        check_eq("t3_valid", 32'(ir_valid), 32'd1);
        check_eq("t3_irpc",  32'(ir_pc),    32'h40);
        check_eq("t3_ir",    32'(ir),       32'h5A40);

        // Test 4: PC wrap from 7'h7F to 0
        redirect    = 1'b1;
        redirect_pc = 7'h7F;
        step(1);
        redirect = 1'b0;
        step(2);
        check_eq("t4_irpc_7f", 32'(ir_pc),    32'h7F);
        check_eq("t4_ir_7f",   32'(ir),       32'h5A7F);
        check_eq("t4_addr_0",  32'(rom_addr), 32'd0);
        step(3);
        check_eq("t4_valid_w", 32'(ir_valid), 32'd1);
        check_eq("t4_irpc_w",  32'(ir_pc),    32'd0);
        check_eq("t4_ir_w",    32'(ir),       32'h1111);

        // Test 5: halt (with a coincident redirect) during CAPTURE, then Reset
        step(2);
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 7'h22;
        step(1);
        halt     = 1'b0;
        redirect = 1'b0;
        check_eq("t5_halted", 32'(halted),   32'd1);
        check_eq("t5_valid",  32'(ir_valid), 32'd0);
        check_eq("t5_addr",   32'(rom_addr), 32'd1);
        check_eq("t5_ir_kept", 32'(ir),      32'h1111);
        for (int i = 0; i < 10; i++) begin
            redirect = (i % 2 == 0);
            step(1);
            check_eq("t5_hold_halted", 32'(halted),   32'd1);
            check_eq("t5_hold_valid",  32'(ir_valid), 32'd0);
            check_eq("t5_hold_addr",   32'(rom_addr), 32'd1);
        end
        redirect = 1'b0;
        do_reset();
        check_eq("t5_unhalt",   32'(halted),   32'd0);
        check_eq("t5_rst_addr", 32'(rom_addr), 32'd0);
        step(2);
        check_eq("t5_resume_valid", 32'(ir_valid), 32'd1);
        check_eq("t5_resume_irpc",  32'(ir_pc),    32'd0);
        check_eq("t5_resume_ir",    32'(ir),       32'h1111);

`ifdef FETCH_STAT_EN
        // Test 6: handshake counter survives redirect, clears on Reset
        check_eq("t6_cnt_start", 32'(fetch_count), 32'd0);
        for (int i = 0; i < 4; i++) step(3);
        check_eq("t6_cnt4", 32'(fetch_count), 32'd4);
        ir_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 7'h10;
        step(1);
        redirect = 1'b0;
        check_eq("t6_cnt_redir", 32'(fetch_count), 32'd4);
        step(2);
        check_eq("t6_cnt_after", 32'(fetch_count), 32'd4);
        do_reset();
        check_eq("t6_cnt_rst", 32'(fetch_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
